// File: rtl/dmem_port_arbiter.sv
// Two-port request/grant arbiter in front of a single-port data memory.
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module dmem_port_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [DW-1:0] p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [DW-1:0] p0_rdata_o,
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [DW-1:0] p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [DW-1:0] p1_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StRwait} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          any_req;
    logic          winner;

    assign any_req = p0_req_i | p1_req_i;

`ifdef ARB_FIXED_PRIO_EN
    // Port 1 only wins when port 0 is not asking.
    always_comb winner = ~p0_req_i;
`else
    logic last_q, last_d;

    always_comb begin
        if (p0_req_i && p1_req_i) begin
            winner = ~last_q;
        end else begin
            winner = ~p0_req_i;
        end
        last_d = (state_q == StIdle && any_req) ? winner : last_q;
    end

    // Reset to 1 so port 0 takes the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d     = StIssue;
                    owner_d     = winner;
                    mem_we_d    = winner ? p1_we_i : p0_we_i;
                    mem_addr_d  = winner ? p1_addr_i : p0_addr_i;
                    mem_wdata_d = winner ? p1_wdata_i : p0_wdata_i;
                end
            end
            StIssue: state_d = mem_we_q ? StIdle : StRwait;
            StRwait: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_en_o    = (state_q == StIssue);
        p0_gnt_o    = (state_q == StIssue) && !owner_q;
        p1_gnt_o    = (state_q == StIssue) && owner_q;
        p0_rvalid_o = (state_q == StRwait) && !owner_q;
        p1_rvalid_o = (state_q == StRwait) && owner_q;
        p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : '0;
        p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : '0;
        busy_o      = (state_q != StIdle);
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter with a behavioural memory and arbitration model.
// Honours ARB_FIXED_PRIO_EN when the design is built with it.
module tb_dmem_port_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FixedPrio = 1'b1;
`else
    localparam bit FixedPrio = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [31:0] rdata [2];
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    bit   [31:0] mem_rdata;
    bit   [31:0] dev_mem [64];
    bit   [31:0] ref_mem [64];
    int          checks = 0;
    int          errors = 0;
    bit          last_m = 1'b1;
    string       scen = "none";

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .p0_req_i(req[0]), .p0_we_i(we[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]),
        .p0_gnt_o(gnt[0]), .p0_rvalid_o(rvalid[0]), .p0_rdata_o(rdata[0]),
        .p1_req_i(req[1]), .p1_we_i(we[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]),
        .p1_gnt_o(gnt[1]), .p1_rvalid_o(rvalid[1]), .p1_rdata_o(rdata[1]),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // Single-port memory device: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr[7:2]] <= mem_wdata;
            else        mem_rdata <= dev_mem[mem_addr[7:2]];
        end
    end

    task automatic wait_idle();
        int c = 0;
        do begin
            @(posedge clk); #1; c++;
        end while (busy !== 1'b0 && c < 10);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_wait: busy=%b want 0", scen, busy);
        end
    endtask

    // Issue one access on each enabled port at the same time and follow them to completion.
    task automatic run_pair(input bit en0, input bit en1, input bit we0, input bit we1,
                            input logic [5:0] a0, input logic [5:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1);
        bit          pend [2];
        bit          erv [2];
        logic [31:0] erd [2];
        int          cyc = 0;
        bit          first_seen = 1'b0;
        bit          exp_p;
        int          p;
        wait_idle();
        req[0] = en0; we[0] = we0; addr[0] = {24'h0, a0, 2'b00}; wdata[0] = d0;
        req[1] = en1; we[1] = we1; addr[1] = {24'h0, a1, 2'b00}; wdata[1] = d1;
        pend[0] = en0; pend[1] = en1;
        erv[0] = 1'b0; erv[1] = 1'b0;
        erd[0] = '0; erd[1] = '0;
        while ((pend[0] || pend[1] || erv[0] || erv[1]) && cyc < 20) begin
            if (pend[0] && pend[1]) exp_p = FixedPrio ? 1'b0 : ~last_m;
            else                    exp_p = pend[1];
            @(posedge clk); #1; cyc++;
            for (int q = 0; q < 2; q++) begin
                checks++;
                if (rvalid[q] !== erv[q]) begin
                    errors++;
                    $display("FAIL %s rvalid%0d: got %b want %b", scen, q, rvalid[q], erv[q]);
                end
                checks++;
                if (rdata[q] !== (erv[q] ? erd[q] : 32'h0)) begin
                    errors++;
                    $display("FAIL %s rdata%0d: got %h want %h", scen, q, rdata[q],
                             erv[q] ? erd[q] : 32'h0);
                end
                erv[q] = 1'b0;
            end
            checks++;
            if (mem_en !== (gnt != 2'b00)) begin
                errors++;
                $display("FAIL %s mem_en: got %b want %b (gnt=%b)", scen, mem_en, gnt != 0, gnt);
            end
            if (gnt == 2'b11) begin
                checks++; errors++;
                $display("FAIL %s dual_grant: got %b want one-hot", scen, gnt);
            end else if (gnt != 2'b00) begin
                p = gnt[1] ? 1 : 0;
                checks++;
                if (p != int'(exp_p) || !pend[p]) begin
                    errors++;
                    $display("FAIL %s grant_port: got %0d want %0d", scen, p, exp_p);
                end
                checks++;
                if (mem_we !== we[p] || mem_addr !== addr[p] || mem_wdata !== wdata[p]) begin
                    errors++;
                    $display("FAIL %s mem_bus: got we=%b a=%h d=%h want we=%b a=%h d=%h", scen,
                             mem_we, mem_addr, mem_wdata, we[p], addr[p], wdata[p]);
                end
                if (!first_seen) begin
                    checks++;
                    if (cyc != 1) begin
                        errors++;
                        $display("FAIL %s grant_latency: got %0d want 1", scen, cyc);
                    end
                    first_seen = 1'b1;
                end
                pend[p] = 1'b0;
                req[p] = 1'b0;
                last_m = p[0];
                if (we[p]) ref_mem[addr[p][7:2]] = wdata[p];
                else begin
                    erv[p] = 1'b1;
                    erd[p] = ref_mem[addr[p][7:2]];
                end
            end
        end
        checks++;
        if (pend[0] || pend[1] || erv[0] || erv[1]) begin
            errors++;
            $display("FAIL %s timeout: got pending=%b%b want 00", scen, pend[1], pend[0]);
        end
        req[0] = 1'b0; req[1] = 1'b0;
    endtask

    task automatic test_reset();
        scen = "reset";
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rvalid, rdata[0], rdata[1], mem_en, mem_we, mem_addr, mem_wdata, busy} !== '0)
        begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b en=%b busy=%b want all 0",
                     gnt, rvalid, mem_en, busy);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({gnt, rvalid, rdata[0], rdata[1], mem_en, mem_we, mem_addr, mem_wdata, busy}
                !== '0) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d: got gnt=%b rv=%b en=%b busy=%b want 0",
                         i, gnt, rvalid, mem_en, busy);
            end
        end
    endtask

    task automatic test_write_read();
        scen = "write_read";
        run_pair(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 6'h4, 32'h0, 32'd55);
        run_pair(1'b1, 1'b0, 1'b0, 1'b0, 6'h4, 6'd0, 32'h0, 32'h0);
    endtask

    task automatic test_contention();
        int          cyc = 0;
        int          k = 0;
        int          lastg = 0;
        int          p;
        int          want;
        bit          erv [2];
        logic [31:0] erd [2];
        scen = "contention";
        erv[0] = 1'b0; erv[1] = 1'b0;
        erd[0] = '0; erd[1] = '0;
        @(posedge clk); #1 rst_n = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h14;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h24;
        @(posedge clk); #1 rst_n = 1'b1;
        while ((k < 12 || erv[0] || erv[1]) && cyc < 60) begin
            @(posedge clk); #1; cyc++;
            for (int q = 0; q < 2; q++) begin
                checks++;
                if (rvalid[q] !== erv[q] || (erv[q] && rdata[q] !== erd[q])) begin
                    errors++;
                    $display("FAIL %s rvalid%0d: got %b/%h want %b/%h", scen, q, rvalid[q],
                             rdata[q], erv[q], erd[q]);
                end
                erv[q] = 1'b0;
            end
            if (gnt != 2'b00) begin
                p = gnt[1] ? 1 : 0;
                want = (k == 11) ? 1 : (FixedPrio ? 0 : k % 2);
                checks++;
                if (gnt == 2'b11 || p != want) begin
                    errors++;
                    $display("FAIL %s grant %0d: got %b want port %0d", scen, k, gnt, want);
                end
                checks++;
                if (cyc - lastg != ((k == 0) ? 1 : 3)) begin
                    errors++;
                    $display("FAIL %s spacing %0d: got %0d want %0d", scen, k, cyc - lastg,
                             (k == 0) ? 1 : 3);
                end
                lastg = cyc;
                erv[p] = 1'b1;
                erd[p] = ref_mem[addr[p][7:2]];
                if (k == 10) req[0] = 1'b0;
                if (k == 11) req[1] = 1'b0;
                k++;
            end
        end
        checks++;
        if (k != 12) begin
            errors++;
            $display("FAIL %s timeout: got %0d grants want 12", scen, k);
        end
        req[0] = 1'b0; req[1] = 1'b0;
        last_m = 1'b1;
    endtask

    task automatic test_reset_mid_rwait();
        int c = 0;
        scen = "reset_rwait";
        wait_idle();
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'hC;
        do begin
            @(posedge clk); #1; c++;
        end while (gnt[0] !== 1'b1 && c < 10);
        req[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rvalid[0] !== 1'b1) begin
            errors++;
            $display("FAIL %s in_rwait: got rvalid0=%b want 1", scen, rvalid[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid[0] !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s async_drop: got rv=%b en=%b busy=%b want 000", scen, rvalid[0],
                     mem_en, busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        last_m = 1'b1;
        run_pair(1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 6'd7, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        int k = 0;
        int lastg = 0;
        scen = "back_to_back";
        wait_idle();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'd1;
        while (k < 3 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            checks++;
            if (mem_en !== gnt[0] || gnt[1] !== 1'b0) begin
                errors++;
                $display("FAIL %s strobe: got en=%b gnt=%b want en==gnt0", scen, mem_en, gnt);
            end
            if (gnt[0]) begin
                checks++;
                if (cyc - lastg != ((k == 0) ? 1 : 2) || mem_addr !== addr[0]
                    || mem_wdata !== wdata[0]) begin
                    errors++;
                    $display("FAIL %s write %0d: got gap=%0d a=%h d=%h want gap=%0d a=%h d=%h",
                             scen, k, cyc - lastg, mem_addr, mem_wdata, (k == 0) ? 1 : 2,
                             addr[0], wdata[0]);
                end
                ref_mem[addr[0][7:2]] = wdata[0];
                lastg = cyc;
                k++;
                if (k < 3) begin
                    addr[0] = 32'(4 * k); wdata[0] = 32'(k + 1);
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL %s timeout: got %0d writes want 3", scen, k);
        end
        req[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_pair(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'(i), 32'h0, 32'h0);
        end
    endtask

    task automatic test_random();
        int m;
        scen = "random";
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(1, 3);
            run_pair(m[0], m[1], 1'($urandom), 1'($urandom), 6'($urandom_range(0, 15)),
                     6'($urandom_range(0, 15)), $urandom, $urandom);
        end
    endtask

    initial begin
        req[0] = 1'b0; we[0] = 1'b0; addr[0] = '0; wdata[0] = '0;
        req[1] = 1'b0; we[1] = 1'b0; addr[1] = '0; wdata[1] = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_reset_mid_rwait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory of the single-cycle CPU between two requesters.
- Port 0 is the CPU load/store path; port 1 is the debug/preload DMA port used by benches to seed and dump memory.
- Serialises accesses with a request/grant handshake and returns read data with fixed latency.
- Sits between the requesters and the memory's enable, write, address and data pins.

Parameters:
- AW, 32, address width; forwarded to memory unchanged (byte address).
- DW, 32, data width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- p0_req_i  in  1  port 0 request; held until p0_gnt_o seen high.
- p0_we_i  in  1  port 0 write (1) / read (0); stable while req high.
- p0_addr_i  in  AW  port 0 address; stable while req high.
- p0_wdata_i  in  DW  port 0 write data; stable while req high.
- p0_gnt_o  out  1  port 0 grant, one-cycle pulse.
- p0_rvalid_o  out  1  port 0 read data valid, one-cycle pulse.
- p0_rdata_o  out  DW  port 0 read data; valid only when p0_rvalid_o is high.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o: same as port 0, for port 1.
- mem_en_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_rdata_i  in  DW  memory read data, valid the cycle after mem_en_o && !mem_we_o.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_i=0, takes effect immediately, independent of clock):
  - state=IDLE, owner=0, last=1 (so port 0 wins the first tie).
  - All outputs 0, including the registered mem_* outputs.
  - Any in-flight access is dropped; no rvalid is issued for it after reset releases.
- FSM states: IDLE, ISSUE, RWAIT.
- IDLE:
  - Stay in IDLE if no request is high.
  - Otherwise select a winner (arbitration rule below) and load owner, mem_we, mem_addr and mem_wdata from the winner's inputs.
  - Go to ISSUE.
- ISSUE (exactly one cycle):
  - mem_en_o=1 and the owner's gnt_o=1; all other strobes 0.
  - If mem_we_o=1, go to IDLE; the write is complete at this clock edge.
  - Otherwise go to RWAIT.
- RWAIT (exactly one cycle):
  - Owner's rvalid_o=1; owner's rdata_o = mem_rdata_i (combinational pass-through).
  - Go to IDLE.
- Outside RWAIT, rdata_o outputs are 0.
- Latency, request sampled high in IDLE at edge N:
  - gnt and mem_en are high in cycle N+1.
  - For reads, rvalid is high in cycle N+2.
  - A new arbitration happens at edge N+2 (write) or N+3 (read).
  - Peak throughput: one write every 2 cycles, one read every 3 cycles.
- Requester rules:
  - A requester may drop req only after the cycle in which its gnt is high.
  - If req is still high after gnt, it is a new request, arbitrated again in IDLE.
  - req dropping before grant is a protocol violation; the arbiter does not check it.
- Arbitration (default, round-robin):
  - Only one request high: that port wins.
  - Both high: the port != last wins.
  - last is updated to owner on entry to ISSUE.
  - Result: with both ports requesting continuously, grants alternate 0,1,0,1.
- Simultaneous events:
  - A request arriving while busy_o=1 waits; it is not queued beyond the held req level.
  - mem_rdata_i is ignored outside RWAIT.
- Address and data pass through unmodified; no alignment check, no wrap logic.
- mem_* outputs hold their last value in IDLE; only mem_en_o qualifies them.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- When defined: port 0 (CPU) wins every tie and the last register is not built. Port 1 is served only in an IDLE cycle where p0_req_i=0.
- When undefined: round-robin as above.

Test Plan:
- Reset release, no requests -> all outputs 0, busy_o=0 for 10 cycles; mem_en_o never asserts.
- p1 write addr=0x10 data=55, then p0 read addr=0x10 -> mem_en_o pulses for each access; p1_gnt_o at N+1; p0_rvalid_o=1 with p0_rdata_o=55 exactly 2 cycles after p0's request is sampled.
- Both ports request reads continuously from reset -> grant order p0,p1,p0,p1; no port is granted twice in a row; one grant per 3 cycles.
- Same as the previous scenario with ARB_FIXED_PRIO_EN defined -> only p0 is granted while p0_req_i stays high; p1 is granted in the first IDLE cycle after p0 drops req.
- Assert rst_i=0 mid-RWAIT of a p0 read -> p0_rvalid_o, mem_en_o and busy_o drop immediately; after release, the first tie is won by p0.
- Back-to-back p0 writes to 0x0,0x4,0x8 (values 1,2,3), then p1 reads of the same addresses -> mem_en_o asserts every 2 cycles during the writes; p1 reads return 1,2,3.
